// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: FSM encoding, slice width
// and a helper to derive the number of slice passes.
package nibble_serial_adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int nibbles_of(input int width);
    return width / NIBBLE_W;
  endfunction

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Operand-in / result-out handshake bundle for the nibble-serial adder.
// master = operand source + result consumer, slave = the adder.
interface nibble_serial_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/nibble_serial_adder_add4.sv
// Combinational 4-bit ripple-carry slice; c3 is the carry into bit 3,
// exposed so the caller can form signed overflow on the final nibble.
module nibble_add4 (
  input  logic [3:0] a4,
  input  logic [3:0] b4,
  input  logic       ci,
  output logic [3:0] s4,
  output logic       co,
  output logic       c3
);
  logic [4:0] c;

  always_comb begin
    // NOTE: every variable written here gets a default first, so no latch is inferred.
    c    = '0;
    s4   = '0;
    c[0] = ci;
    for (int i = 0; i < 4; i++) begin
      s4[i]  = a4[i] ^ b4[i] ^ c[i];
      c[i+1] = (a4[i] & b4[i]) | (a4[i] & c[i]) | (b4[i] & c[i]);
    end
  end

  assign co = c[4];
  assign c3 = c[3];
endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder that pushes one nibble per cycle through a shared 4-bit
// slice, LSB first, with the inter-nibble carry held in a register.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic clk,
  input  logic rst,
  nibble_serial_adder_if.slave bus
);
  localparam int NIBBLES = nibbles_of(WIDTH);
  localparam int CNT_W   = $clog2(NIBBLES) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NIBBLES - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic [NIBBLE_W-1:0] slice_s;
  logic                slice_co;
  logic                slice_c3;
  logic [WIDTH-1:0]    sum_next;

  nibble_add4 u_slice (
    .a4 (a_sh[NIBBLE_W-1:0]),
    .b4 (b_sh[NIBBLE_W-1:0]),
    .ci (carry),
    .s4 (slice_s),
    .co (slice_co),
    .c3 (slice_c3)
  );

  // New nibble enters at the top; after NIBBLES passes the sum is in place.
  // Written as shift-and-or so WIDTH=4 needs no special case.
  always_comb begin
    sum_next = (sum_q >> NIBBLE_W) | (WIDTH'(slice_s) << (WIDTH - NIBBLE_W));
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // right-hand side sees the pre-edge value.
    if (rst) begin
      state       <= IDLE;
      a_sh        <= '0;
      b_sh        <= '0;
      carry       <= 1'b0;
      cnt         <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_sh       <= bus.a;
            b_sh       <= bus.b;
            carry      <= bus.cin;
            cnt        <= '0;
            in_ready_q <= 1'b0;
            state      <= ADD;
          end
        end
        ADD: begin
          sum_q <= sum_next;
          carry <= slice_co;
          a_sh  <= a_sh >> NIBBLE_W;
          b_sh  <= b_sh >> NIBBLE_W;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            cout_q      <= slice_co;
            ovf_q       <= slice_c3 ^ slice_co;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
endmodule
